// File: rtl/sseg_scan_mux_pkg.sv
// Shared constants for the seven-segment scan multiplexer: segment bit
// positions and the active-low hex glyph table.
package sseg_scan_mux_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Index is the hex value; bit SEG_A..SEG_G, 0 = segment lit.
   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/sseg_scan_mux_hex7seg_dec.sv
// Combinational hex nibble to active-low a..g segment decoder.
module hex7seg_dec
   import sseg_scan_mux_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = HEX7_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous double
// buffering, anode guard blanking and optional leading-zero blanking.
module sseg_scan_mux
   import sseg_scan_mux_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 2,
   parameter int LZB          = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              sseg,
   output logic                    frame_start
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;
   logic [4*NUM_DIGITS-1:0] stage_dig_r;
   logic [NUM_DIGITS-1:0]   stage_dp_r;
   logic [4*NUM_DIGITS-1:0] act_dig_r;
   logic [NUM_DIGITS-1:0]   act_dp_r;
   logic                    pending_r;
   logic                    wrap_d_r;
   logic [NUM_DIGITS-1:0]   an_r;
   logic [7:0]              sseg_r;
   logic                    frame_start_r;

   logic                    tick_s;
   logic                    wrap_s;
   logic [3:0]              nib_s;
   logic [6:0]              seg_dec_s;
   logic [NUM_DIGITS-1:0]   blank_s;
   logic [NUM_DIGITS-1:0]   an_next_s;
   logic [7:0]              sseg_next_s;

   assign tick_s = (cnt_r == CNT_LAST);
   assign wrap_s = tick_s && (idx_r == IDX_LAST);
   assign nib_s  = act_dig_r[{idx_r, 2'b00} +: 4];

   hex7seg_dec u_dec (
      .nibble (nib_s),
      .seg_n  (seg_dec_s)
   );

   // Prescaler and slot index; wrap_d_r marks the first cycle of a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CNT_W{1'b0}};
         idx_r    <= {IDX_W{1'b0}};
         wrap_d_r <= 1'b0;
      end else begin
         wrap_d_r <= wrap_s;
         if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
               idx_r <= {IDX_W{1'b0}};
            end else begin
               idx_r <= idx_r + IDX_W'(1);
            end
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Staging/active double buffer: active only changes on the frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_dig_r <= {(4*NUM_DIGITS){1'b0}};
         stage_dp_r  <= {NUM_DIGITS{1'b0}};
         act_dig_r   <= {(4*NUM_DIGITS){1'b0}};
         act_dp_r    <= {NUM_DIGITS{1'b0}};
         pending_r   <= 1'b0;
      end else if (load && wrap_s) begin
         act_dig_r <= digits;
         act_dp_r  <= dp;
         pending_r <= 1'b0;
      end else if (load) begin
         stage_dig_r <= digits;
         stage_dp_r  <= dp;
         pending_r   <= 1'b1;
      end else if (wrap_s && pending_r) begin
         act_dig_r <= stage_dig_r;
         act_dp_r  <= stage_dp_r;
         pending_r <= 1'b0;
      end
   end

   // A digit is blanked when it and every more-significant digit are zero.
   always_comb begin
      logic higher_zero;
      logic is_zero;
      higher_zero = 1'b1;
      blank_s     = {NUM_DIGITS{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         is_zero     = (act_dig_r[4*i +: 4] == 4'h0);
         blank_s[i]  = (LZB != 0) && (i != 0) && higher_zero && is_zero;
         higher_zero = higher_zero && is_zero;
      end
   end

   // Next anode and segment values for the current slot position.
   always_comb begin
      an_next_s   = {NUM_DIGITS{1'b1}};
      sseg_next_s = 8'hFF;
      if (cnt_r < CNT_BLANK) begin
         an_next_s = {NUM_DIGITS{1'b1}};
      end else begin
         an_next_s[idx_r] = ~digit_en[idx_r];
      end
      sseg_next_s[SEG_DP] = ~act_dp_r[idx_r];
      if (blank_s[idx_r]) begin
         sseg_next_s[SEG_G:SEG_A] = 7'h7F;
      end else begin
         sseg_next_s[SEG_G:SEG_A] = seg_dec_s;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r          <= {NUM_DIGITS{1'b1}};
         sseg_r        <= 8'hFF;
         frame_start_r <= 1'b0;
      end else begin
         an_r          <= an_next_s;
         sseg_r        <= sseg_next_s;
         frame_start_r <= wrap_d_r;
      end
   end

   assign an          = an_r;
   assign sseg        = sseg_r;
   assign frame_start = frame_start_r;

endmodule
